// File: rtl/ppu_pkg.sv
// Shared types and register map for the PPU layer compositor.
package ppu_pkg;
   typedef logic [23:0] rgb_t;

   localparam rgb_t TRANSPARENT_KEY = 24'h202020;

   localparam logic [2:0] PPU_REG_ENABLE = 3'd0;
   localparam logic [2:0] PPU_REG_BG     = 3'd1;
   localparam logic [2:0] PPU_REG_KEY    = 3'd2;
   localparam logic [2:0] PPU_REG_COLL   = 3'd3;
endpackage

// File: rtl/ppu_prio_group.sv
// 4-input priority selector: lowest-index opaque input wins.
module ppu_prio_group #(
   parameter int COLOR_W = 24
) (
   input  logic [3:0]           opq_i,
   input  logic [4*COLOR_W-1:0] col_i,
   output logic                 hit_o,
   output logic [1:0]           idx_o,
   output logic [COLOR_W-1:0]   col_o
);
   always_comb begin
      hit_o = |opq_i;
      idx_o = '0;
      col_o = '0;
      for (int k = 3; k >= 0; k--) begin
         if (opq_i[k]) begin
            idx_o = 2'(k);
            col_o = col_i[k*COLOR_W +: COLOR_W];
         end
      end
   end
endmodule

// File: rtl/ppu_layer_compositor.sv
// Two-stage layer compositor: stage 1 pre-muxes 4-layer groups, stage 2 merges
// groups, drives the RGB output and tracks per-frame layer collisions.
module ppu_layer_compositor
   import ppu_pkg::*;
#(
   parameter int                 NUM_LAYERS  = 20,
   parameter int                 COLOR_W     = 24,
   parameter logic [COLOR_W-1:0] KEY_DEFAULT = TRANSPARENT_KEY,
   parameter int                 ID_W        = $clog2(NUM_LAYERS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          write,
   input  logic                          read,
   input  logic [2:0]                    address,
   input  logic [31:0]                   writedata,
   output logic [31:0]                   readdata,
   input  logic [9:0]                    hcount,
   input  logic [9:0]                    vcount,
   input  logic                          pixel_valid,
   input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
   output logic [COLOR_W-1:0]            rgb_out,
   output logic                          rgb_valid,
   output logic [ID_W-1:0]               layer_id,
   output logic                          bg_sel
);
   localparam int NG = (NUM_LAYERS + 3) / 4;

   logic [NUM_LAYERS-1:0]       enable_q, coll_q, acc_q, opq_d, s1_opq_q;
   logic [COLOR_W-1:0]          bg_q, key_q, s1_bg_q;
   logic [31:0]                 readdata_q, rd_d;
   logic [NG-1:0]               grp_hit_d, s1_hit_q;
   logic [NG-1:0][1:0]          grp_idx_d, s1_idx_q;
   logic [NG-1:0][COLOR_W-1:0]  grp_col_d, s1_col_q;
   logic [2:1]                  vld_pipe_q;
   logic                        s1_fs_q, frame_start_d, multi_d;
   logic                        sel_hit_d;
   logic [ID_W-1:0]             sel_id_d;
   logic [COLOR_W-1:0]          sel_col_d;

   assign frame_start_d = pixel_valid && (hcount == '0) && (vcount == '0);

   for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_opq
      assign opq_d[i] = enable_q[i] && (layer_rgb[i*COLOR_W +: COLOR_W] != key_q);
   end

   // Slots past NUM_LAYERS in the last group are tied non-opaque.
   for (genvar g = 0; g < NG; g++) begin : g_grp
      logic [3:0]           g_opq;
      logic [4*COLOR_W-1:0] g_col;
      for (genvar k = 0; k < 4; k++) begin : g_slot
         localparam int L = g*4 + k;
         if (L < NUM_LAYERS) begin : g_used
            assign g_opq[k]                      = opq_d[L];
            assign g_col[k*COLOR_W +: COLOR_W]   = layer_rgb[L*COLOR_W +: COLOR_W];
         end else begin : g_pad
            assign g_opq[k]                      = 1'b0;
            assign g_col[k*COLOR_W +: COLOR_W]   = '0;
         end
      end
      ppu_prio_group #(.COLOR_W(COLOR_W)) u_grp (
         .opq_i (g_opq),
         .col_i (g_col),
         .hit_o (grp_hit_d[g]),
         .idx_o (grp_idx_d[g]),
         .col_o (grp_col_d[g])
      );
   end

   always_comb begin
      rd_d = '0;
      case (address)
         PPU_REG_ENABLE: rd_d = 32'(enable_q);
         PPU_REG_BG:     rd_d = 32'(bg_q);
         PPU_REG_KEY:    rd_d = 32'(key_q);
         PPU_REG_COLL:   rd_d = 32'(coll_q);
         default:        rd_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable_q   <= '1;
         bg_q       <= '0;
         key_q      <= KEY_DEFAULT;
         readdata_q <= '0;
      end else begin
         if (write) begin
            case (address)
               PPU_REG_ENABLE: enable_q <= writedata[NUM_LAYERS-1:0];
               PPU_REG_BG:     bg_q     <= writedata[COLOR_W-1:0];
               PPU_REG_KEY:    key_q    <= writedata[COLOR_W-1:0];
               default: ;
            endcase
         end
         if (read) readdata_q <= rd_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_pipe_q[1] <= 1'b0;
         s1_fs_q       <= 1'b0;
         s1_opq_q      <= '0;
         s1_bg_q       <= '0;
         s1_hit_q      <= '0;
         s1_idx_q      <= '0;
         s1_col_q      <= '0;
      end else begin
         vld_pipe_q[1] <= pixel_valid;
         s1_fs_q       <= frame_start_d;
         if (pixel_valid) begin
            s1_opq_q <= opq_d;
            s1_bg_q  <= bg_q;
            s1_hit_q <= grp_hit_d;
            s1_idx_q <= grp_idx_d;
            s1_col_q <= grp_col_d;
         end
      end
   end

   always_comb begin
      sel_hit_d = 1'b0;
      sel_id_d  = '0;
      sel_col_d = s1_bg_q;
      for (int g = NG-1; g >= 0; g--) begin
         if (s1_hit_q[g]) begin
            sel_hit_d = 1'b1;
            sel_id_d  = ID_W'(g*4) + ID_W'(s1_idx_q[g]);
            sel_col_d = s1_col_q[g];
         end
      end
   end

   // Two or more bits set: clearing the lowest set bit leaves something.
   assign multi_d = |(s1_opq_q & (s1_opq_q - NUM_LAYERS'(1)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_pipe_q[2] <= 1'b0;
         rgb_out       <= '0;
         layer_id      <= '0;
         bg_sel        <= 1'b0;
         acc_q         <= '0;
         coll_q        <= '0;
      end else begin
         vld_pipe_q[2] <= vld_pipe_q[1];
         if (vld_pipe_q[1]) begin
            rgb_out  <= sel_col_d;
            layer_id <= sel_id_d;
            bg_sel   <= !sel_hit_d;
            if (s1_fs_q) begin
               coll_q <= acc_q;
               acc_q  <= multi_d ? s1_opq_q : '0;
            end else if (multi_d) begin
               acc_q  <= acc_q | s1_opq_q;
            end
         end
      end
   end

   assign rgb_valid = vld_pipe_q[2];
   assign readdata  = readdata_q;
endmodule

// File: tb/tb_ppu_layer_compositor.sv
// Self-checking bench for ppu_layer_compositor: directed scenarios plus a
// randomized stream compared against a first-opaque-layer reference model.
module tb_ppu_layer_compositor;
   localparam int NL  = 20;
   localparam int CW  = 24;
   localparam int IDW = 5;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 write = 1'b0;
   logic                 read = 1'b0;
   logic [2:0]           address = '0;
   logic [31:0]          writedata = '0;
   logic [31:0]          readdata;
   logic [9:0]           hcount = 10'd5;
   logic [9:0]           vcount = 10'd5;
   logic                 pixel_valid = 1'b0;
   logic [NL-1:0][CW-1:0] lay;
   logic [CW-1:0]        rgb_out;
   logic                 rgb_valid;
   logic [IDW-1:0]       layer_id;
   logic                 bg_sel;

   int checks = 0;
   int failures = 0;

   logic [NL-1:0] m_en, m_acc, m_coll;
   logic [CW-1:0] m_bg, m_key;

   typedef struct {
      logic [CW-1:0]  rgb;
      logic [IDW-1:0] id;
      logic           bg;
   } exp_t;

   ppu_layer_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW)) dut (
      .clk(clk), .reset(reset), .write(write), .read(read),
      .address(address), .writedata(writedata), .readdata(readdata),
      .hcount(hcount), .vcount(vcount), .pixel_valid(pixel_valid),
      .layer_rgb(lay), .rgb_out(rgb_out), .rgb_valid(rgb_valid),
      .layer_id(layer_id), .bg_sel(bg_sel)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_en = '1; m_bg = '0; m_key = 24'h202020; m_acc = '0; m_coll = '0;
   endtask

   task automatic fill(input logic [CW-1:0] c);
      for (int i = 0; i < NL; i++) lay[i] = c;
   endtask

   task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
      write = 1'b1; address = a; writedata = d;
      tick();
      write = 1'b0;
      case (a)
         3'd0: m_en = d[NL-1:0];
         3'd1: m_bg = d[CW-1:0];
         3'd2: m_key = d[CW-1:0];
         default: ;
      endcase
   endtask

   task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
      read = 1'b1; address = a;
      tick();
      read = 1'b0;
      d = readdata;
   endtask

   // Predicts one valid pixel from current inputs and advances the collision model.
   task automatic model_pix(output logic [CW-1:0] e_rgb, output logic [IDW-1:0] e_id,
                            output logic e_bg);
      logic [NL-1:0] m;
      int win;
      m = '0;
      win = -1;
      for (int i = 0; i < NL; i++)
         if (m_en[i] && lay[i] != m_key) begin
            m[i] = 1'b1;
            if (win < 0) win = i;
         end
      if (win < 0) begin e_rgb = m_bg; e_id = '0; e_bg = 1'b1; end
      else begin e_rgb = lay[win]; e_id = IDW'(win); e_bg = 1'b0; end
      if (hcount == 0 && vcount == 0) begin m_coll = m_acc; m_acc = '0; end
      if ($countones(m) >= 2) m_acc = m_acc | m;
   endtask

   task automatic send_one(output exp_t e);
      pixel_valid = 1'b1;
      model_pix(e.rgb, e.id, e.bg);
      tick();
      pixel_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [31:0] d;
      #2;
      checks++;
      if (rgb_valid !== 1'b0 || rgb_out !== '0 || layer_id !== '0 || bg_sel !== 1'b0
          || readdata !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got v=%b rgb=%h id=%0d bg=%b rd=%h want all 0",
                  rgb_valid, rgb_out, layer_id, bg_sel, readdata);
      end
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reg_rd(3'd0, d); checks++;
      if (d !== 32'h000F_FFFF) begin failures++; $display("FAIL reset_enable: got %h want 000fffff", d); end
      reg_rd(3'd1, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_bg: got %h want 0", d); end
      reg_rd(3'd2, d); checks++;
      if (d !== 32'h0020_2020) begin failures++; $display("FAIL reset_key: got %h want 00202020", d); end
      reg_rd(3'd3, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_coll: got %h want 0", d); end
      reg_wr(3'd5, 32'hFFFF_FFFF);
      reg_rd(3'd5, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reserved_read: got %h want 0", d); end
   endtask

   task automatic test_priority();
      exp_t e;
      fill(24'h202020);
      lay[3] = 24'hFF0000; lay[5] = 24'h00FF00; lay[14] = 24'h0000FF;
      hcount = 10'd5; vcount = 10'd5;
      send_one(e);
      checks++;
      if (rgb_valid !== 1'b1 || rgb_out !== 24'hFF0000 || layer_id !== 5'd3 || bg_sel !== 1'b0) begin
         failures++;
         $display("FAIL priority: got v=%b rgb=%h id=%0d bg=%b want 1 ff0000 3 0",
                  rgb_valid, rgb_out, layer_id, bg_sel);
      end
      tick();
      checks++;
      if (rgb_valid !== 1'b0 || rgb_out !== 24'hFF0000 || layer_id !== 5'd3) begin
         failures++;
         $display("FAIL hold: got v=%b rgb=%h id=%0d want 0 ff0000 3", rgb_valid, rgb_out, layer_id);
      end
   endtask

   task automatic test_enable();
      exp_t e;
      reg_wr(3'd0, 32'h000F_FFF7);
      send_one(e);
      checks++;
      if (rgb_out !== 24'h00FF00 || layer_id !== 5'd5 || bg_sel !== 1'b0) begin
         failures++;
         $display("FAIL enable_mask: got rgb=%h id=%0d bg=%b want 00ff00 5 0", rgb_out, layer_id, bg_sel);
      end
      reg_wr(3'd0, 32'hFFFF_FFFF);
   endtask

   task automatic test_bg_key();
      exp_t e;
      reg_wr(3'd1, 32'h005C_94FC);
      fill(24'h202020);
      send_one(e);
      checks++;
      if (rgb_out !== 24'h5C94FC || bg_sel !== 1'b1 || layer_id !== '0) begin
         failures++;
         $display("FAIL bg_default_key: got rgb=%h bg=%b id=%0d want 5c94fc 1 0", rgb_out, bg_sel, layer_id);
      end
      reg_wr(3'd2, 32'h0);
      fill(24'h000000);
      send_one(e);
      checks++;
      if (rgb_out !== 24'h5C94FC || bg_sel !== 1'b1 || layer_id !== '0) begin
         failures++;
         $display("FAIL bg_key_zero: got rgb=%h bg=%b id=%0d want 5c94fc 1 0", rgb_out, bg_sel, layer_id);
      end
      reg_wr(3'd2, 32'h0020_2020);
   endtask

   task automatic test_collision();
      exp_t e;
      logic [31:0] d;
      fill(24'h202020); hcount = 10'd0; vcount = 10'd0;
      send_one(e);
      lay[3] = 24'hFF0000; lay[5] = 24'h00FF00; hcount = 10'd5; vcount = 10'd7;
      send_one(e);
      fill(24'h202020); hcount = 10'd0; vcount = 10'd0;
      send_one(e);
      reg_rd(3'd3, d); checks++;
      if (d !== 32'h28) begin failures++; $display("FAIL coll_overlap: got %h want 28", d); end
      lay[7] = 24'h123456; hcount = 10'd9; vcount = 10'd2;
      send_one(e);
      fill(24'h202020); hcount = 10'd0; vcount = 10'd0;
      send_one(e);
      reg_rd(3'd3, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL coll_clean_frame: got %h want 0", d); end
      // Frame-start pixel contributes to the new frame's accumulator.
      lay[0] = 24'h010101; lay[1] = 24'h020202;
      send_one(e);
      fill(24'h202020);
      send_one(e);
      reg_rd(3'd3, d); checks++;
      if (d !== 32'h3) begin failures++; $display("FAIL coll_self_contrib: got %h want 3", d); end
      lay[0] = 24'h010101; lay[2] = 24'h030303; hcount = 10'd4; vcount = 10'd4;
      send_one(e);
      // Read and BG write collide with the snapshot update.
      fill(24'h202020); hcount = 10'd0; vcount = 10'd0;
      pixel_valid = 1'b1; write = 1'b1; address = 3'd1; writedata = 32'h0000_AA00;
      model_pix(e.rgb, e.id, e.bg);
      tick();
      pixel_valid = 1'b0; write = 1'b0; m_bg = 24'h00AA00;
      read = 1'b1; address = 3'd3;
      tick();
      read = 1'b0;
      checks++;
      if (readdata !== 32'h3 || rgb_out !== e.rgb || bg_sel !== 1'b1) begin
         failures++;
         $display("FAIL coll_read_at_snapshot: got rd=%h rgb=%h bg=%b want 3 %h 1",
                  readdata, rgb_out, bg_sel, e.rgb);
      end
      reg_rd(3'd3, d); checks++;
      if (d !== 32'h5) begin failures++; $display("FAIL coll_after_snapshot: got %h want 5", d); end
   endtask

   task automatic rand_pixel(input int n);
      for (int i = 0; i < NL; i++)
         lay[i] = ($urandom_range(0, 1) == 1 || (n % 10) == 0) ? m_key : CW'($urandom);
      if ($urandom_range(0, 7) == 0) begin hcount = '0; vcount = '0; end
      else begin hcount = 10'($urandom_range(1, 639)); vcount = 10'($urandom_range(0, 479)); end
   endtask

   task automatic test_back_to_back();
      exp_t q[$];
      exp_t e, p;
      logic [31:0] d;
      reg_wr(3'd0, $urandom);
      reg_wr(3'd1, $urandom);
      for (int n = 0; n < 102; n++) begin
         if (n >= 2) begin
            p = q.pop_front();
            checks++;
            if (rgb_valid !== 1'b1 || rgb_out !== p.rgb || layer_id !== p.id || bg_sel !== p.bg) begin
               failures++;
               $display("FAIL b2b_pix%0d: got v=%b rgb=%h id=%0d bg=%b want 1 %h %0d %b",
                        n-2, rgb_valid, rgb_out, layer_id, bg_sel, p.rgb, p.id, p.bg);
            end
         end
         if (n < 100) begin
            rand_pixel(n);
            pixel_valid = 1'b1;
            model_pix(e.rgb, e.id, e.bg);
            q.push_back(e);
         end else begin
            pixel_valid = 1'b0;
         end
         tick();
      end
      reg_rd(3'd3, d); checks++;
      if (d !== 32'(m_coll)) begin failures++; $display("FAIL b2b_coll: got %h want %h", d, m_coll); end
   endtask

   task automatic test_reset_midstream();
      exp_t e;
      logic [31:0] d;
      reg_wr(3'd1, 32'h0012_3456);
      reg_wr(3'd0, 32'h0000_FFFF);
      pixel_valid = 1'b1;
      for (int n = 0; n < 5; n++) begin
         rand_pixel(n + 1);
         tick();
      end
      #3 reset = 1'b0;
      #1;
      checks++;
      if (rgb_valid !== 1'b0 || rgb_out !== '0 || layer_id !== '0 || bg_sel !== 1'b0
          || readdata !== '0) begin
         failures++;
         $display("FAIL async_reset: got v=%b rgb=%h id=%0d bg=%b rd=%h want all 0",
                  rgb_valid, rgb_out, layer_id, bg_sel, readdata);
      end
      pixel_valid = 1'b0;
      tick();
      reset = 1'b1;
      model_reset();
      reg_rd(3'd1, d); checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_mid_bg: got %h want 0", d); end
      reg_rd(3'd0, d); checks++;
      if (d !== 32'h000F_FFFF) begin failures++; $display("FAIL reset_mid_enable: got %h want 000fffff", d); end
      fill(24'h202020);
      lay[11] = 24'hABCDEF; lay[19] = 24'h111111; hcount = 10'd3; vcount = 10'd3;
      pixel_valid = 1'b1;
      model_pix(e.rgb, e.id, e.bg);
      tick();
      pixel_valid = 1'b0;
      checks++;
      if (rgb_valid !== 1'b0) begin failures++; $display("FAIL post_reset_early: got v=%b want 0", rgb_valid); end
      tick();
      checks++;
      if (rgb_valid !== 1'b1 || rgb_out !== 24'hABCDEF || layer_id !== 5'd11 || bg_sel !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_latency: got v=%b rgb=%h id=%0d bg=%b want 1 abcdef 11 0",
                  rgb_valid, rgb_out, layer_id, bg_sel);
      end
   endtask

   initial begin
      model_reset();
      fill(24'h202020);
      test_reset();
      test_priority();
      test_enable();
      test_bg_key();
      test_collision();
      test_back_to_back();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
